tlul_to_reg_adapter: RTL and testbench

//  TL-UL device-side adapter: accepts one TL-UL A-channel request, checks it, issues it as a register-interface

---
 rtl/tlul_to_reg_adapter.sv | 247 ++++++++++++++++++++++++
 tb/tb_tlul_to_reg_adapter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_to_reg_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tlul_to_reg_adapter (with companion package tlul_pkg)      |
// | Description : TL-UL device-side adapter. Accepts one A-channel request,  |
// |               checks it, and either issues it as a register-interface    |
// |               transaction or answers it directly with an error. Returns  |
// |               the matching D-channel response. There is one outstanding  |
// |               transaction at most, and requests are not pipelined.       |
// | Ports       : clk_i     - clock, all state updates on the rising edge    |
// |               rst_i     - synchronous active-high reset                  |
// |               tl_i      - TL-UL A channel plus d_ready from the host     |
// |               tl_o      - TL-UL D channel plus a_ready to the host       |
// |               reg_req_o - register-interface request to the peripheral   |
// |               reg_rsp_i - register-interface response from the peripheral|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] OpPutFullData    = 3'h0;
  localparam logic [2:0] OpPutPartialData = 3'h1;
  localparam logic [2:0] OpGet            = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] OpAccessAck      = 3'h0;
  localparam logic [2:0] OpAccessAckData  = 3'h1;

  localparam logic [7:0] TlDUserDefault   = 8'h00;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [7:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

module tlul_to_reg_adapter #(
  parameter type req_t    = tlul_pkg::reg_req_t,
  parameter type rsp_t    = tlul_pkg::reg_rsp_t,
  parameter type tl_h2d_t = tlul_pkg::tl_h2d_t,
  parameter type tl_d2h_t = tlul_pkg::tl_d2h_t,
  parameter int  AW       = 32
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output req_t    reg_req_o,
  input  rsp_t    reg_rsp_i
);

  import tlul_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e       state_q;
  logic         a_ready_q;
  logic         d_valid_q;
  logic         req_valid_q;
  logic [2:0]   opcode_q;
  logic [1:0]   size_q;
  logic [7:0]   source_q;
  logic [AW-1:0] addr_q;
  logic [31:0]  wdata_q;
  logic [3:0]   mask_q;
  logic [31:0]  rdata_q;
  logic         err_q;

  // ---------------------------------------------------------------------
  // Request legality, evaluated on the raw A channel at capture time
  // ---------------------------------------------------------------------
  logic [3:0] full_mask;
  logic       opcode_ok;
  logic       size_ok;
  logic       align_ok;
  logic       mask_ok;
  logic       req_err;

  // Byte lanes a full-width access of a_size must cover at this offset
  always_comb begin
    full_mask = 4'b0000;
    case (tl_i.a_size)
      2'd0:    full_mask = 4'b0001 << tl_i.a_address[1:0];
      2'd1:    full_mask = 4'b0011 << tl_i.a_address[1:0];
      default: full_mask = 4'b1111 << tl_i.a_address[1:0];
    endcase
  end

  always_comb begin
    align_ok = 1'b0;
    case (tl_i.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~tl_i.a_address[0];
      2'd2:    align_ok = (tl_i.a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign opcode_ok = (tl_i.a_opcode == OpGet) ||
                     (tl_i.a_opcode == OpPutFullData) ||
                     (tl_i.a_opcode == OpPutPartialData);
  assign size_ok   = (tl_i.a_size != 2'd3);
  // Partial puts may carry any mask; only full puts must cover the access
  assign mask_ok   = (tl_i.a_opcode != OpPutFullData) || (tl_i.a_mask == full_mask);
  assign req_err   = !opcode_ok || !size_ok || !align_ok || !mask_ok;

  // ---------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_ready_q   <= 1'b1;
      d_valid_q   <= 1'b0;
      req_valid_q <= 1'b0;
      opcode_q    <= '0;
      size_q      <= '0;
      source_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tl_i.a_valid) begin
            opcode_q  <= tl_i.a_opcode;
            size_q    <= tl_i.a_size;
            source_q  <= tl_i.a_source;
            addr_q    <= tl_i.a_address[AW-1:0];
            wdata_q   <= tl_i.a_data;
            mask_q    <= tl_i.a_mask;
            rdata_q   <= '0;
            err_q     <= req_err;
            a_ready_q <= 1'b0;
            if (req_err) begin
              // Illegal requests never reach the peripheral
              d_valid_q <= 1'b1;
              state_q   <= RSP;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (reg_rsp_i.ready) begin
            req_valid_q <= 1'b0;
            err_q       <= err_q | reg_rsp_i.error;
            // Read data is only returned for a successful Get
            if ((opcode_q == OpGet) && !reg_rsp_i.error) begin
              rdata_q <= reg_rsp_i.rdata;
            end
            d_valid_q <= 1'b1;
            state_q   <= RSP;
          end
        end
        RSP: begin
          if (tl_i.d_ready) begin
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output mapping (all sources are registers)
  // ---------------------------------------------------------------------
  logic is_write;
  assign is_write = (opcode_q != OpGet);

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.valid = req_valid_q;
    reg_req_o.write = is_write;
    reg_req_o.addr  = addr_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = is_write ? mask_q : 4'b0000;
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = is_write ? OpAccessAck : OpAccessAckData;
    tl_o.d_param  = 3'b000;
    tl_o.d_size   = size_q;
    tl_o.d_source = source_q;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = rdata_q;
    tl_o.d_user   = TlDUserDefault;
    tl_o.d_error  = err_q;
    tl_o.a_ready  = a_ready_q;
  end

  // A-channel fields with no meaning for a register peripheral
  logic unused_tl_bits;
  assign unused_tl_bits = ^{tl_i.a_param, tl_i.a_user};

endmodule
`default_nettype wire

// File: tb/tb_tlul_to_reg_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tlul_to_reg_adapter                                     |
// | Description : Self-checking bench for tlul_to_reg_adapter. Directed      |
// |               scenarios followed by randomized transactions, all checked |
// |               against a transaction-level reference model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tlul_to_reg_adapter;

  import tlul_pkg::*;

  logic     clk;
  logic     rst_i;
  tl_h2d_t  tl_i;
  tl_d2h_t  tl_o;
  reg_req_t reg_req;
  reg_rsp_t reg_rsp;

  int checks = 0;
  int errors = 0;

  tlul_to_reg_adapter dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .tl_i      (tl_i),
    .tl_o      (tl_o),
    .reg_req_o (reg_req),
    .reg_rsp_i (reg_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  opc;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
    logic [31:0] rdata;
    logic        perr;
    int          wwait;
    int          dwait;
  } txn_t;

  function automatic txn_t mk(input logic [2:0] opc, input logic [1:0] size,
                              input logic [31:0] addr, input logic [3:0] mask,
                              input logic [31:0] data, input logic [7:0] src,
                              input logic [31:0] rdata, input logic perr,
                              input int wwait, input int dwait);
    txn_t t;
    t.opc = opc; t.size = size; t.addr = addr; t.mask = mask; t.data = data;
    t.src = src; t.rdata = rdata; t.perr = perr; t.wwait = wwait; t.dwait = dwait;
    return t;
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: legality and expected response from the request rules
  // ---------------------------------------------------------------------
  function automatic bit m_bad(input txn_t t);
    int nbytes;
    int off;
    int want;
    if (!(t.opc == OpGet || t.opc == OpPutFullData || t.opc == OpPutPartialData)) return 1'b1;
    if (int'(t.size) > 2) return 1'b1;
    nbytes = 1 << int'(t.size);
    off    = int'(t.addr[1:0]);
    if ((off % nbytes) != 0) return 1'b1;
    want = (((1 << nbytes) - 1) << off) & 15;
    if (t.opc == OpPutFullData && int'(t.mask) != want) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_derr(input txn_t t);
    return m_bad(t) || t.perr;
  endfunction

  function automatic logic [31:0] m_ddata(input txn_t t);
    return (t.opc == OpGet && !m_derr(t)) ? t.rdata : 32'h0;
  endfunction

  function automatic logic [2:0] m_dopc(input txn_t t);
    return (t.opc == OpGet) ? OpAccessAckData : OpAccessAck;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus helpers; all called at a falling edge
  // ---------------------------------------------------------------------
  task automatic drive_a(input txn_t t);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = t.opc;
    tl_i.a_param   = 3'h0;
    tl_i.a_size    = t.size;
    tl_i.a_source  = t.src;
    tl_i.a_address = t.addr;
    tl_i.a_mask    = t.mask;
    tl_i.a_data    = t.data;
    tl_i.a_user    = 8'h00;
  endtask

  task automatic send_a(input txn_t t);
    drive_a(t);
    chk("a_ready_idle", tl_o.a_ready, 1'b1);
    @(negedge clk);
    tl_i.a_valid   = 1'b0;
    tl_i.a_address = $urandom;
    tl_i.a_data    = $urandom;
  endtask

  task automatic reg_phase(input txn_t t);
    if (m_bad(t)) begin
      chk("err_no_reg_valid", reg_req.valid, 1'b0);
      chk("err_d_valid_next", tl_o.d_valid, 1'b1);
      return;
    end
    for (int i = 0; i <= t.wwait; i++) begin
      chk("reg_valid", reg_req.valid, 1'b1);
      chk("reg_addr", reg_req.addr, t.addr);
      chk("reg_write", reg_req.write, t.opc != OpGet);
      chk("reg_wdata", reg_req.wdata, t.data);
      chk("reg_wstrb", reg_req.wstrb, (t.opc != OpGet) ? t.mask : 4'h0);
      chk("reg_a_ready", tl_o.a_ready, 1'b0);
      chk("reg_d_valid", tl_o.d_valid, 1'b0);
      if (i == t.wwait) begin
        reg_rsp.ready = 1'b1;
        reg_rsp.rdata = t.rdata;
        reg_rsp.error = t.perr;
      end else begin
        reg_rsp.ready = 1'b0;
        reg_rsp.rdata = $urandom;
        reg_rsp.error = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    reg_rsp.ready = 1'b0;
    reg_rsp.rdata = $urandom;
    reg_rsp.error = 1'b0;
    chk("reg_valid_drop", reg_req.valid, 1'b0);
  endtask

  task automatic d_phase(input txn_t t);
    for (int i = 0; i <= t.dwait; i++) begin
      chk("d_valid", tl_o.d_valid, 1'b1);
      chk("d_opcode", tl_o.d_opcode, m_dopc(t));
      chk("d_size", tl_o.d_size, t.size);
      chk("d_source", tl_o.d_source, t.src);
      chk("d_data", tl_o.d_data, m_ddata(t));
      chk("d_error", tl_o.d_error, m_derr(t));
      chk("d_param_sink_user", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 32'h0);
      chk("d_a_ready", tl_o.a_ready, 1'b0);
      chk("d_reg_valid", reg_req.valid, 1'b0);
      tl_i.d_ready  = (i == t.dwait);
      // Peripheral chatter outside REQ must not disturb anything
      reg_rsp.ready = 1'($urandom_range(0, 1));
      reg_rsp.error = 1'($urandom_range(0, 1));
      reg_rsp.rdata = $urandom;
      @(negedge clk);
    end
    tl_i.d_ready  = 1'b0;
    reg_rsp.ready = 1'b0;
    reg_rsp.error = 1'b0;
    chk("d_valid_drop", tl_o.d_valid, 1'b0);
    chk("a_ready_back", tl_o.a_ready, 1'b1);
  endtask

  task automatic run(input txn_t t);
    send_a(t);
    reg_phase(t);
    d_phase(t);
  endtask

  // ---------------------------------------------------------------------
  // Directed scenarios, then randomized traffic
  // ---------------------------------------------------------------------
  initial begin
    txn_t t;
    txn_t t2;
    logic [2:0] bad_ops [5];
    bad_ops = '{3'h2, 3'h3, 3'h5, 3'h6, 3'h7};

    tl_i    = '0;
    reg_rsp = '0;
    rst_i   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_a_ready", tl_o.a_ready, 1'b1);
    chk("rst_d_valid", tl_o.d_valid, 1'b0);
    chk("rst_reg_valid", reg_req.valid, 1'b0);
    chk("rst_reg_addr", reg_req.addr, 32'h0);
    chk("rst_reg_wdata", reg_req.wdata, 32'h0);
    chk("rst_reg_wstrb", reg_req.wstrb, 4'h0);
    chk("rst_d_fields", {tl_o.d_size, tl_o.d_source, tl_o.d_error}, 32'h0);
    chk("rst_d_data", tl_o.d_data, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);

    // T1: Get, peripheral ready in the same cycle
    run(mk(OpGet, 2'd2, 32'h100, 4'hF, 32'h0, 8'd3, 32'hDEADBEEF, 1'b0, 0, 0));
    // T2: PutFullData, peripheral ready after 4 wait cycles
    run(mk(OpPutFullData, 2'd2, 32'h104, 4'hF, 32'h12345678, 8'd5, 32'hFFFFFFFF, 1'b0, 4, 1));
    // T3: PutPartialData with peripheral error
    run(mk(OpPutPartialData, 2'd1, 32'h102, 4'hC, 32'hA5A5A5A5, 8'd9, 32'h0, 1'b1, 0, 0));
    // T4: requests rejected without a register access
    run(mk(OpGet, 2'd2, 32'h101, 4'hF, 32'h0, 8'd1, 32'h11111111, 1'b0, 0, 0));
    run(mk(3'h7, 2'd2, 32'h200, 4'hF, 32'h55, 8'd2, 32'h0, 1'b0, 0, 0));
    run(mk(OpPutFullData, 2'd2, 32'h108, 4'h7, 32'h66, 8'd4, 32'h0, 1'b0, 0, 2));

    // T5: D backpressure with a second request waiting on the A channel
    t  = mk(OpPutFullData, 2'd2, 32'h10C, 4'hF, 32'h0BADF00D, 8'd7, 32'h0, 1'b0, 1, 6);
    t2 = mk(OpGet, 2'd2, 32'h110, 4'hF, 32'h0, 8'd8, 32'hCAFEF00D, 1'b0, 0, 0);
    send_a(t);
    reg_phase(t);
    drive_a(t2);
    d_phase(t);
    send_a(t2);
    reg_phase(t2);
    d_phase(t2);

    // T6: reset while the register request is outstanding
    t = mk(OpPutFullData, 2'd2, 32'h300, 4'hF, 32'h77777777, 8'd6, 32'h0, 1'b0, 3, 0);
    send_a(t);
    chk("t6_in_req", reg_req.valid, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_reg_valid_clr", reg_req.valid, 1'b0);
    chk("t6_a_ready", tl_o.a_ready, 1'b1);
    chk("t6_reg_wstrb_clr", reg_req.wstrb, 4'h0);
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'h12121212;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_d_valid", tl_o.d_valid, 1'b0);
      chk("t6_no_reg_valid", reg_req.valid, 1'b0);
      @(negedge clk);
    end
    reg_rsp.ready = 1'b0;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      int r;
      int off;
      r = int'($urandom_range(0, 9));
      if (r < 4)      t.opc = OpGet;
      else if (r < 7) t.opc = OpPutFullData;
      else if (r < 9) t.opc = OpPutPartialData;
      else            t.opc = bad_ops[$urandom_range(0, 4)];
      t.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && t.size != 2'd3)
        off = off - (off % (1 << int'(t.size)));
      t.addr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      if ($urandom_range(0, 3) != 0 && t.size != 2'd3)
        t.mask = 4'((((1 << (1 << int'(t.size))) - 1) << off) & 15);
      else
        t.mask = 4'($urandom_range(0, 15));
      t.data  = $urandom;
      t.src   = 8'($urandom);
      t.rdata = $urandom;
      t.perr  = ($urandom_range(0, 3) == 0);
      t.wwait = int'($urandom_range(0, 3));
      t.dwait = int'($urandom_range(0, 3));
      run(t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
